// File: rtl/sw_engine_dispatch_if.sv
// Host/engine/DRAM signal bundle for the Smith-Waterman dispatch front-end.
// The slave modport is the dispatcher's view; master is the surrounding fabric.
interface sw_engine_dispatch_if #(
  parameter int NUM_ENG    = 4,
  parameter int NUM_PES    = 64,
  parameter int REF_LENGTH = 256,
  parameter int CHAR_BITS  = 2
);
  localparam int EW = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;
  localparam int QW = NUM_PES * CHAR_BITS;
  localparam int RW = REF_LENGTH * CHAR_BITS;

  logic                        stall;
  logic [24:0]                 ref_length_in, ref_addr_in;
  logic [15:0]                 num_query_blocks_in;
  logic                        query_info_valid, query_info_rdy_out;
  logic [QW-1:0]               query_seq_block_in;
  logic                        query_seq_block_valid, query_seq_block_rdy_out;
  logic [EW-1:0]               job_engine_out;
  logic [24:0]                 eng_ref_length_out, eng_ref_addr_out;
  logic [15:0]                 eng_num_query_blocks_out;
  logic [NUM_ENG-1:0]          eng_query_info_valid_out, eng_query_info_rdy_in;
  logic [QW-1:0]               eng_query_block_out;
  logic [NUM_ENG-1:0]          eng_query_block_valid_out, eng_query_block_rdy_in;
  logic [NUM_ENG-1:0][24:0]    eng_ref_addr_in, eng_ref_length_in;
  logic [NUM_ENG-1:0]          eng_ref_info_valid_in, eng_done_in;
  logic [24:0]                 dram_ref_addr_out, dram_ref_length_out;
  logic                        dram_ref_info_valid_out, dram_ref_info_rdy_in;
  logic [RW-1:0]               dram_ref_block_in;
  logic                        dram_ref_block_valid, dram_ref_block_rdy_out;
  logic [RW-1:0]               eng_ref_block_out;
  logic [NUM_ENG-1:0]          eng_ref_block_valid_out, eng_ref_block_rdy_in;
  logic [NUM_ENG-1:0]          eng_busy_out;
  logic                        err_overrun_out;

  modport slave (
    input  stall, ref_length_in, ref_addr_in, num_query_blocks_in, query_info_valid,
           query_seq_block_in, query_seq_block_valid, eng_query_info_rdy_in,
           eng_query_block_rdy_in, eng_ref_addr_in, eng_ref_length_in, eng_ref_info_valid_in,
           eng_done_in, dram_ref_info_rdy_in, dram_ref_block_in, dram_ref_block_valid,
           eng_ref_block_rdy_in,
    output query_info_rdy_out, query_seq_block_rdy_out, job_engine_out, eng_ref_length_out,
           eng_ref_addr_out, eng_num_query_blocks_out, eng_query_info_valid_out,
           eng_query_block_out, eng_query_block_valid_out, dram_ref_addr_out,
           dram_ref_length_out, dram_ref_info_valid_out, dram_ref_block_rdy_out,
           eng_ref_block_out, eng_ref_block_valid_out, eng_busy_out, err_overrun_out
  );

  modport master (
    output stall, ref_length_in, ref_addr_in, num_query_blocks_in, query_info_valid,
           query_seq_block_in, query_seq_block_valid, eng_query_info_rdy_in,
           eng_query_block_rdy_in, eng_ref_addr_in, eng_ref_length_in, eng_ref_info_valid_in,
           eng_done_in, dram_ref_info_rdy_in, dram_ref_block_in, dram_ref_block_valid,
           eng_ref_block_rdy_in,
    input  query_info_rdy_out, query_seq_block_rdy_out, job_engine_out, eng_ref_length_out,
           eng_ref_addr_out, eng_num_query_blocks_out, eng_query_info_valid_out,
           eng_query_block_out, eng_query_block_valid_out, dram_ref_addr_out,
           dram_ref_length_out, dram_ref_info_valid_out, dram_ref_block_rdy_out,
           eng_ref_block_out, eng_ref_block_valid_out, eng_busy_out, err_overrun_out
  );
endinterface

// File: rtl/sw_engine_dispatch.sv
// Round-robin job dispatcher and DRAM reference-read arbiter for a cluster of
// Smith-Waterman engines; query and reference paths run as independent FSMs.
module sw_engine_dispatch #(
  parameter int NUM_ENG    = 4,
  parameter int NUM_PES    = 64,
  parameter int REF_LENGTH = 256,
  parameter int CHAR_BITS  = 2
) (
  input logic             clk,
  input logic             rst_n,
  sw_engine_dispatch_if.slave bus
);
  localparam int EW = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;

  typedef enum logic [1:0] {Q_IDLE, Q_INFO, Q_BLK}  q_state_t;
  typedef enum logic [1:0] {R_IDLE, R_REQ, R_STRM} r_state_t;

  function automatic logic [EW-1:0] wrap_inc(input logic [EW-1:0] v);
    int t;
    t = int'(v) + 1;
    if (t >= NUM_ENG) t = 0;
    return EW'(t);
  endfunction

  // First set bit of mask scanning circularly from base.
  function automatic logic [EW-1:0] rr_pick(input logic [NUM_ENG-1:0] mask,
                                            input logic [EW-1:0] base);
    logic [EW-1:0] res;
    logic          found;
    int            j;
    res   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_ENG; k++) begin
      j = int'(base) + k;
      if (j >= NUM_ENG) j = j - NUM_ENG;
      if (!found && mask[EW'(j)]) begin
        found = 1'b1;
        res   = EW'(j);
      end
    end
    return res;
  endfunction

  logic                     r_run;
  q_state_t                 r_qs, w_qs_nx;
  logic [EW-1:0]            r_rr_q, r_qeng, w_pick;
  logic [NUM_ENG-1:0]       r_busy, w_busy_set;
  logic [24:0]              r_len, r_addr;
  logic [15:0]              r_nqb, r_qcnt;
  r_state_t                 r_rs, w_rs_nx;
  logic [EW-1:0]            r_rr_r, r_g, w_gsel;
  logic [NUM_ENG-1:0]       r_pend, w_inflight, w_req_ok, w_req_bad, w_gclr;
  logic [NUM_ENG-1:0][24:0] r_req_addr, r_req_len;
  logic [24:0]              r_daddr, r_dlen, r_rcnt;
  logic                     r_err;
  logic w_go, w_any_free, w_info_acc, w_einfo_acc, w_blk_xfer;
  logic w_grant, w_dreq_acc, w_rblk_xfer;

  // r_run keeps every handshake output low during reset and the first cycle after it.
  assign w_go        = r_run & ~bus.stall;
  assign w_any_free  = |(~r_busy);
  assign w_pick      = rr_pick(~r_busy, r_rr_q);
  assign w_info_acc  = w_go && r_qs == Q_IDLE && w_any_free && bus.query_info_valid;
  assign w_einfo_acc = w_go && r_qs == Q_INFO && bus.eng_query_info_rdy_in[r_qeng];
  assign w_blk_xfer  = w_go && r_qs == Q_BLK && bus.query_seq_block_valid
                       && bus.eng_query_block_rdy_in[r_qeng];
  assign w_busy_set  = w_info_acc ? (NUM_ENG'(1) << w_pick) : '0;

  assign bus.job_engine_out           = r_qeng;
  assign bus.eng_ref_length_out       = r_len;
  assign bus.eng_ref_addr_out         = r_addr;
  assign bus.eng_num_query_blocks_out = r_nqb;
  assign bus.eng_query_block_out      = bus.query_seq_block_in[NUM_PES*CHAR_BITS-1:0];
  assign bus.eng_busy_out             = r_busy;
  assign bus.err_overrun_out          = r_err;

  always_comb begin
    w_qs_nx                       = r_qs;
    bus.query_info_rdy_out        = 1'b0;
    bus.eng_query_info_valid_out  = '0;
    bus.eng_query_block_valid_out = '0;
    bus.query_seq_block_rdy_out   = 1'b0;
    case (r_qs)
      Q_IDLE: begin
        bus.query_info_rdy_out = w_go & w_any_free;
        if (w_info_acc) w_qs_nx = Q_INFO;
      end
      Q_INFO: begin
        bus.eng_query_info_valid_out[r_qeng] = w_go;
        if (w_einfo_acc) w_qs_nx = (r_nqb == 16'd0) ? Q_IDLE : Q_BLK;
      end
      Q_BLK: begin
        bus.eng_query_block_valid_out[r_qeng] = w_go & bus.query_seq_block_valid;
        bus.query_seq_block_rdy_out           = w_go & bus.eng_query_block_rdy_in[r_qeng];
        if (w_blk_xfer && r_qcnt == 16'd1) w_qs_nx = Q_IDLE;
      end
      default: w_qs_nx = Q_IDLE;
    endcase
  end

  // Done pulses are single-cycle events and are taken even while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run  <= 1'b0;
      r_qs   <= Q_IDLE;
      r_rr_q <= '0;
      r_qeng <= '0;
      r_busy <= '0;
      r_len  <= '0;
      r_addr <= '0;
      r_nqb  <= '0;
      r_qcnt <= '0;
    end else begin
      r_run  <= 1'b1;
      r_qs   <= w_qs_nx;
      r_busy <= (r_busy & ~bus.eng_done_in) | w_busy_set;
      if (w_info_acc) begin
        r_len  <= bus.ref_length_in;
        r_addr <= bus.ref_addr_in;
        r_nqb  <= bus.num_query_blocks_in;
        r_qeng <= w_pick;
        r_rr_q <= wrap_inc(w_pick);
      end
      if (w_einfo_acc)     r_qcnt <= r_nqb;
      else if (w_blk_xfer) r_qcnt <= r_qcnt - 16'd1;
    end
  end

  // An engine already pending or currently being served cannot queue another request.
  assign w_inflight  = (r_rs != R_IDLE) ? (NUM_ENG'(1) << r_g) : '0;
  assign w_req_ok    = bus.eng_ref_info_valid_in & ~r_pend & ~w_inflight;
  assign w_req_bad   = bus.eng_ref_info_valid_in & ~w_req_ok;
  assign w_gsel      = rr_pick(r_pend, r_rr_r);
  assign w_grant     = w_go && r_rs == R_IDLE && |r_pend;
  assign w_gclr      = w_grant ? (NUM_ENG'(1) << w_gsel) : '0;
  assign w_dreq_acc  = w_go && r_rs == R_REQ && bus.dram_ref_info_rdy_in;
  assign w_rblk_xfer = w_go && r_rs == R_STRM && bus.dram_ref_block_valid
                       && bus.eng_ref_block_rdy_in[r_g];

  assign bus.dram_ref_addr_out   = r_daddr;
  assign bus.dram_ref_length_out = r_dlen;
  assign bus.eng_ref_block_out   = bus.dram_ref_block_in[REF_LENGTH*CHAR_BITS-1:0];

  always_comb begin
    w_rs_nx                     = r_rs;
    bus.dram_ref_info_valid_out = 1'b0;
    bus.dram_ref_block_rdy_out  = 1'b0;
    bus.eng_ref_block_valid_out = '0;
    case (r_rs)
      R_IDLE: if (w_grant) w_rs_nx = R_REQ;
      R_REQ: begin
        bus.dram_ref_info_valid_out = w_go;
        if (w_dreq_acc) w_rs_nx = (r_dlen == 25'd0) ? R_IDLE : R_STRM;
      end
      R_STRM: begin
        bus.eng_ref_block_valid_out[r_g] = w_go & bus.dram_ref_block_valid;
        bus.dram_ref_block_rdy_out       = w_go & bus.eng_ref_block_rdy_in[r_g];
        if (w_rblk_xfer && r_rcnt == 25'd1) w_rs_nx = R_IDLE;
      end
      default: w_rs_nx = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rs       <= R_IDLE;
      r_rr_r     <= '0;
      r_g        <= '0;
      r_pend     <= '0;
      r_req_addr <= '0;
      r_req_len  <= '0;
      r_daddr    <= '0;
      r_dlen     <= '0;
      r_rcnt     <= '0;
      r_err      <= 1'b0;
    end else begin
      r_rs   <= w_rs_nx;
      r_pend <= (r_pend & ~w_gclr) | w_req_ok;
      for (int i = 0; i < NUM_ENG; i++) begin
        if (w_req_ok[i]) begin
          r_req_addr[i] <= bus.eng_ref_addr_in[i];
          r_req_len[i]  <= bus.eng_ref_length_in[i];
        end
      end
      if (|w_req_bad) r_err <= 1'b1;
      if (w_grant) begin
        r_g     <= w_gsel;
        r_rr_r  <= wrap_inc(w_gsel);
        r_daddr <= r_req_addr[w_gsel];
        r_dlen  <= r_req_len[w_gsel];
      end
      if (w_dreq_acc)       r_rcnt <= r_dlen;
      else if (w_rblk_xfer) r_rcnt <= r_rcnt - 25'd1;
    end
  end
endmodule

// File: tb/tb_sw_engine_dispatch.sv
// Directed bench for sw_engine_dispatch: table-driven job dispatch plus
// hand-written ref arbitration, stall, overrun and mid-operation reset sequences.
module tb_sw_engine_dispatch;
  localparam int NE = 4, NP = 64, RL = 256, CB = 2;
  localparam int QW = NP * CB, RW = RL * CB;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sw_engine_dispatch_if #(.NUM_ENG(NE), .NUM_PES(NP), .REF_LENGTH(RL), .CHAR_BITS(CB)) bus();
  sw_engine_dispatch #(.NUM_ENG(NE), .NUM_PES(NP), .REF_LENGTH(RL), .CHAR_BITS(CB))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] done;
    int         nqb;
    int         eng;
    logic [3:0] busy;
  } job_t;
  job_t jobs[8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string pfx);
    chk({pfx, "_info_rdy"},  bus.query_info_rdy_out, 0);
    chk({pfx, "_blk_rdy"},   bus.query_seq_block_rdy_out, 0);
    chk({pfx, "_einfo_v"},   bus.eng_query_info_valid_out, 0);
    chk({pfx, "_eblk_v"},    bus.eng_query_block_valid_out, 0);
    chk({pfx, "_eref_v"},    bus.eng_ref_block_valid_out, 0);
    chk({pfx, "_dram_req"},  bus.dram_ref_info_valid_out, 0);
    chk({pfx, "_dram_rdy"},  bus.dram_ref_block_rdy_out, 0);
    chk({pfx, "_busy"},      bus.eng_busy_out, 0);
    chk({pfx, "_err"},       bus.err_overrun_out, 0);
  endtask

  task automatic send_job(input int nqb, input int eng, input logic [3:0] busy);
    int n, cnt;
    bus.ref_addr_in         = 25'h1000 + 25'(eng);
    bus.ref_length_in       = 25'(100 + nqb);
    bus.num_query_blocks_in = 16'(nqb);
    bus.query_info_valid    = 1'b1;
    n = 0;
    while (!bus.query_info_rdy_out && n < 50) begin tick(); n++; end
    chk("info_rdy_wait", n < 50, 1);
    tick();
    bus.query_info_valid = 1'b0;
    chk("job_engine", bus.job_engine_out, eng);
    chk("busy", bus.eng_busy_out, busy);
    chk("eng_info_valid", bus.eng_query_info_valid_out, 4'b1 << eng);
    chk("eng_nqb", bus.eng_num_query_blocks_out, nqb);
    chk("eng_addr", bus.eng_ref_addr_out, 25'h1000 + 25'(eng));
    tick();
    bus.query_seq_block_valid = 1'b1;
    if (nqb == 0) begin
      #1;
      chk("zero_blk_rdy", bus.query_seq_block_rdy_out, 0);
      chk("zero_blk_valid", bus.eng_query_block_valid_out, 0);
      chk("zero_back_idle", bus.query_info_rdy_out, busy != 4'hF);
      tick();
    end else begin
      cnt = 0;
      n = 0;
      while (cnt < nqb && n < 100) begin
        bus.query_seq_block_in = {4{32'(cnt + 1)}};
        #1;
        if (cnt == 0) chk("blk_valid_onehot", bus.eng_query_block_valid_out, 4'b1 << eng);
        if (bus.query_seq_block_rdy_out) begin
          chk("blk_data", bus.eng_query_block_out == {4{32'(cnt + 1)}}, 1);
          cnt++;
        end
        tick();
        n++;
      end
      chk("blk_count", cnt, nqb);
      chk("blk_no_extra", bus.query_seq_block_rdy_out, 0);
    end
    bus.query_seq_block_valid = 1'b0;
  endtask

  task automatic ref_req(input int e, input logic [24:0] addr, input logic [24:0] len);
    bus.eng_ref_addr_in[e]   = addr;
    bus.eng_ref_length_in[e] = len;
    bus.eng_ref_info_valid_in[e] = 1'b1;
  endtask

  task automatic dram_serve(input logic [24:0] addr, input int len, input int g, input bit rnd);
    int n, got;
    logic [RW-1:0] blk;
    n = 0;
    while (!bus.dram_ref_info_valid_out && n < 50) begin tick(); n++; end
    chk("dram_req_seen", n < 50, 1);
    chk("dram_addr", bus.dram_ref_addr_out, addr);
    chk("dram_len", bus.dram_ref_length_out, len);
    bus.dram_ref_info_rdy_in = 1'b1;
    tick();
    bus.dram_ref_info_rdy_in = 1'b0;
    bus.dram_ref_block_valid = 1'b1;
    got = 0;
    n = 0;
    while (got < len && n < 2000) begin
      blk = {16{32'(g * 256 + got)}};
      bus.dram_ref_block_in = blk;
      if (rnd) begin
        bus.stall = ($urandom_range(0, 3) == 0);
        bus.eng_ref_block_rdy_in[g] = 1'($urandom_range(0, 1));
      end
      #1;
      if (bus.stall) begin
        chk("stall_no_rdy", {bus.dram_ref_block_rdy_out, bus.query_info_rdy_out}, 0);
        chk("stall_no_valid", bus.eng_ref_block_valid_out, 0);
      end else begin
        chk("ref_valid_onehot", bus.eng_ref_block_valid_out, 4'b1 << g);
      end
      if (bus.eng_ref_block_valid_out[g] && bus.eng_ref_block_rdy_in[g]) begin
        chk("ref_data", bus.eng_ref_block_out == blk, 1);
        chk("dram_rdy_match", bus.dram_ref_block_rdy_out, 1);
        got++;
      end
      tick();
      n++;
    end
    bus.stall = 1'b0;
    bus.eng_ref_block_rdy_in = '1;
    chk("ref_count", got, len);
    #1;
    chk("ref_no_extra", bus.dram_ref_block_rdy_out, 0);
    bus.dram_ref_block_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    jobs[0] = '{4'b0000, 3, 0, 4'b0001};
    jobs[1] = '{4'b0000, 3, 1, 4'b0011};
    jobs[2] = '{4'b0000, 3, 2, 4'b0111};
    jobs[3] = '{4'b0000, 3, 3, 4'b1111};
    jobs[4] = '{4'b0100, 3, 2, 4'b1111};
    jobs[5] = '{4'b1001, 0, 3, 4'b1110};
    jobs[6] = '{4'b0000, 1, 0, 4'b1111};
    jobs[7] = '{4'b1111, 2, 1, 4'b0010};

    bus.stall = 1'b0;
    bus.ref_length_in = '0;
    bus.ref_addr_in = '0;
    bus.num_query_blocks_in = '0;
    bus.query_info_valid = 1'b0;
    bus.query_seq_block_in = '0;
    bus.query_seq_block_valid = 1'b0;
    bus.eng_query_info_rdy_in = '1;
    bus.eng_query_block_rdy_in = '1;
    bus.eng_ref_addr_in = '0;
    bus.eng_ref_length_in = '0;
    bus.eng_ref_info_valid_in = '0;
    bus.eng_done_in = '0;
    bus.dram_ref_info_rdy_in = 1'b0;
    bus.dram_ref_block_in = '0;
    bus.dram_ref_block_valid = 1'b0;
    bus.eng_ref_block_rdy_in = '1;

    #12;
    chk_quiet("rst");
    chk("rst_job_engine", bus.job_engine_out, 0);
    rst_n = 1'b1;
    tick();

    // Dispatch table: optional done pulse, then one job.
    for (int i = 0; i < 8; i++) begin
      if (jobs[i].done != 4'b0) begin
        bus.eng_done_in = jobs[i].done;
        tick();
        bus.eng_done_in = '0;
      end
      send_job(jobs[i].nqb, jobs[i].eng, jobs[i].busy);
      if (jobs[i].busy == 4'hF) begin
        bus.query_info_valid = 1'b1;
        tick();
        chk("full_info_rdy", bus.query_info_rdy_out, 0);
        tick();
        chk("full_no_einfo", bus.eng_query_info_valid_out, 0);
        bus.query_info_valid = 1'b0;
      end
    end

    // Engines 1 and 3 request together; engine 1 is served first.
    ref_req(1, 25'h100, 25'd2);
    ref_req(3, 25'h300, 25'd5);
    tick();
    bus.eng_ref_info_valid_in = '0;
    dram_serve(25'h100, 2, 1, 1'b0);
    dram_serve(25'h300, 5, 3, 1'b0);

    // Random stall and engine backpressure during a stream.
    ref_req(2, 25'h222, 25'd6);
    tick();
    bus.eng_ref_info_valid_in = '0;
    dram_serve(25'h222, 6, 2, 1'b1);

    // Overrun: second pulse while still pending.
    chk("err_before", bus.err_overrun_out, 0);
    ref_req(0, 25'h40, 25'd1);
    tick();
    ref_req(0, 25'h50, 25'd3);
    tick();
    bus.eng_ref_info_valid_in = '0;
    chk("err_set", bus.err_overrun_out, 1);
    dram_serve(25'h40, 1, 0, 1'b0);
    n = 0;
    for (int k = 0; k < 10; k++) begin
      if (bus.dram_ref_info_valid_out) n++;
      tick();
    end
    chk("overrun_single_req", n, 0);
    chk("err_sticky", bus.err_overrun_out, 1);

    // Mid-operation reset: park query in block phase and ref in stream phase.
    bus.eng_done_in = '1;
    tick();
    bus.eng_done_in = '0;
    bus.eng_query_block_rdy_in = '0;
    bus.num_query_blocks_in = 16'd3;
    bus.query_info_valid = 1'b1;
    n = 0;
    while (!bus.query_info_rdy_out && n < 50) begin tick(); n++; end
    tick();
    bus.query_info_valid = 1'b0;
    tick();
    bus.query_seq_block_valid = 1'b1;
    ref_req(2, 25'h77, 25'd4);
    tick();
    bus.eng_ref_info_valid_in = '0;
    n = 0;
    while (!bus.dram_ref_info_valid_out && n < 50) begin tick(); n++; end
    bus.dram_ref_info_rdy_in = 1'b1;
    tick();
    bus.dram_ref_info_rdy_in = 1'b0;
    bus.eng_ref_block_rdy_in = '0;
    bus.dram_ref_block_valid = 1'b1;
    #1;
    chk("pre_rst_qblk_valid", |bus.eng_query_block_valid_out, 1);
    chk("pre_rst_ref_valid", bus.eng_ref_block_valid_out, 4'b0100);
    #2;
    rst_n = 1'b0;
    #1;
    chk_quiet("midrst");
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_qblk_valid", bus.eng_query_block_valid_out, 0);
    chk("post_rst_ref_valid", bus.eng_ref_block_valid_out, 0);
    bus.query_seq_block_valid = 1'b0;
    bus.dram_ref_block_valid = 1'b0;
    bus.eng_query_block_rdy_in = '1;
    bus.eng_ref_block_rdy_in = '1;
    tick();

    send_job(2, 0, 4'b0001);
    ref_req(1, 25'h111, 25'd1);
    tick();
    bus.eng_ref_info_valid_in = '0;
    dram_serve(25'h111, 1, 1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
